// File: rtl/down_counter_ctrl.sv
// Loadable down-counter sequencer with start, pause, abort and terminal-count pulse.
// Optional feature macro: AUTO_RELOAD_EN (reload from the latched start value at terminal count).
module down_counter_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (load_val != '0) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = RUN;
          end else begin
            count_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (count_q <= WIDTH'(1)) begin
          // Terminal count: the 1->0 edge carries the done pulse
          done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
          count_d = reload_q;
          state_d = RUN;
`else
          count_d = '0;
          state_d = IDLE;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      PAUSE: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Self-checking bench for down_counter_ctrl: a behavioural countdown model compared every
// cycle, plus directed scenarios with literal expectations. Honours AUTO_RELOAD_EN.
module tb_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] load_val = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] count;
  logic       busy;
  logic       done;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  logic check_en = 1'b0;

  // Model: remaining count, mode (0 idle, 1 run, 2 paused), pulse flag, reload value
  int m_count = 0;
  int m_mode = 0;
  int m_done = 0;
  int m_reload = 0;

  down_counter_ctrl #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val),
    .pause(pause), .abort(abort), .count(count), .busy(busy),
    .done(done), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_count <= 0; m_mode <= 0; m_done <= 0; m_reload <= 0;
    end else begin
      m_done <= 0;
      if (m_mode == 0) begin
        if (start && load_val == 0) m_done <= 1;
        else if (start) begin
          m_count <= int'(load_val); m_reload <= int'(load_val); m_mode <= 1;
        end
      end else if (abort) begin
        m_count <= 0; m_mode <= 0;
      end else if (m_mode == 2) begin
        if (!pause) m_mode <= 1;
      end else if (pause) begin
        m_mode <= 2;
      end else if (m_count - 1 == 0) begin
        m_done <= 1;
`ifdef AUTO_RELOAD_EN
        m_count <= m_reload;
`else
        m_count <= 0; m_mode <= 0;
`endif
      end else begin
        m_count <= m_count - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [5:0] lv, input logic p, input logic a);
    start = s; load_val = lv; pause = p; abort = a;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (check_en && !rst) begin
      checkOutput("model_count", int'(count), m_count);
      checkOutput("model_state", int'(state), m_mode);
      checkOutput("model_busy", int'(busy), (m_mode != 0) ? 1 : 0);
      checkOutput("model_done", int'(done), m_done);
    end
  end

  initial begin
    int exp_cnt[6];
    int exp6[7];
    int done6[7];

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check_en = 1'b1;
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_state", int'(state), 0);

    // Test 1: asynchronous reset mid-count at 17
    applyStimulus(1, 6'd20, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("t1_pre_count", int'(count), 17);
    rst = 1'b1;
    #1;
    checkOutput("t1_async_count", int'(count), 0);
    checkOutput("t1_async_busy", int'(busy), 0);
    checkOutput("t1_async_done", int'(done), 0);
    checkOutput("t1_async_state", int'(state), 0);
    repeat (2) tick();
    rst = 1'b0;

    // Test 2: countdown from 5
`ifdef AUTO_RELOAD_EN
    exp_cnt = '{5, 4, 3, 2, 1, 5};
`else
    exp_cnt = '{5, 4, 3, 2, 1, 0};
`endif
    applyStimulus(1, 6'd5, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) applyStimulus(0, 0, 0, 0);
      checkOutput("t2_count", int'(count), exp_cnt[i]);
      checkOutput("t2_done", int'(done), (i == 5) ? 1 : 0);
`ifdef AUTO_RELOAD_EN
      checkOutput("t2_busy", int'(busy), 1);
`else
      checkOutput("t2_busy", int'(busy), (i < 5) ? 1 : 0);
`endif
    end
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_idle_state", int'(state), 0);

    // Test 3: pause for 3 cycles at 7
    applyStimulus(1, 6'd10, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("t3_pre_count", int'(count), 7);
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3_pause_state", int'(state), 2);
      checkOutput("t3_pause_count", int'(count), 7);
    end
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("t3_resume_state", int'(state), 1);
    checkOutput("t3_resume_count", int'(count), 7);
    tick();
    checkOutput("t3_after_count", int'(count), 6);
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);

    // Test 4: abort at 40 with a simultaneous start
    applyStimulus(1, 6'd63, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    repeat (23) tick();
    checkOutput("t4_pre_count", int'(count), 40);
    applyStimulus(1, 6'd9, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_abort_count", int'(count), 0);
    checkOutput("t4_abort_state", int'(state), 0);
    checkOutput("t4_abort_done", int'(done), 0);
    tick();
    checkOutput("t4_still_idle", int'(state), 0);
    checkOutput("t4_still_done", int'(done), 0);

    // Test 5: zero-length countdown, then start during RUN
    applyStimulus(1, 6'd0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t5_zero_done", int'(done), 1);
    checkOutput("t5_zero_busy", int'(busy), 0);
    checkOutput("t5_zero_state", int'(state), 0);
    tick();
    checkOutput("t5_zero_done_off", int'(done), 0);
    applyStimulus(1, 6'd4, 0, 0);
    tick();
    checkOutput("t5_run_count", int'(count), 4);
    applyStimulus(1, 6'd9, 0, 0);
    tick();
    checkOutput("t5_ignore1", int'(count), 3);
    tick();
    checkOutput("t5_ignore2", int'(count), 2);
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);

    // Test 6: reload behaviour with load value 3
`ifdef AUTO_RELOAD_EN
    exp6 = '{3, 2, 1, 3, 2, 1, 3};
    done6 = '{0, 0, 0, 1, 0, 0, 1};
`else
    exp6 = '{3, 2, 1, 0, 0, 0, 0};
    done6 = '{0, 0, 0, 1, 0, 0, 0};
`endif
    applyStimulus(1, 6'd3, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) applyStimulus(0, 0, 0, 0);
      checkOutput("t6_count", int'(count), exp6[i]);
      checkOutput("t6_done", int'(done), done6[i]);
    end
    applyStimulus(0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("t6_abort_state", int'(state), 0);
    checkOutput("t6_abort_count", int'(count), 0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
